// File: rtl/cnn_pkg.sv
//------------------------------------------------------------------------------
// Module   : cnn_pkg
// Brief    : Shared defaults, FSM state type and saturation helpers for the
//            convolution MAC datapath.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cnn_pkg;

    localparam int c_data_w_def = 8;
    localparam int c_ksize_def  = 3;
    localparam int c_out_w_def  = 17;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } mac_state_t;

    // Width of a counter able to index taps-1; never narrower than one bit.
    function automatic int tap_cnt_w(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    // Clamp a sign-extended value into the signed range of a w-bit result.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mac_sat_stage.sv
//------------------------------------------------------------------------------
// Module   : mac_sat_stage
// Brief    : Final-tap sum (acc + product + bias) with saturation to OUT_W.
//            Optional ReLU activation when MAC_RELU_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mac_sat_stage
    import cnn_pkg::*;
#(
    parameter int ACC_W = 21,
    parameter int OUT_W = 17
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [ACC_W-1:0] prod,
    input  logic signed [OUT_W-1:0] bias,
    output logic signed [OUT_W-1:0] sat_pix,
    output logic                    sat_ovf
);

    logic signed [ACC_W-1:0] w_sum;
    logic signed [63:0]      w_sum64;
    logic signed [63:0]      w_clamp;

    assign w_sum   = acc + prod + ACC_W'(bias);
    assign w_sum64 = 64'(w_sum);
    assign w_clamp = sat(w_sum64, OUT_W);

`ifdef MAC_RELU_EN
    // Negative sums collapse to zero, so only the upper clamp counts as overflow.
    assign sat_pix = w_clamp[63] ? '0 : OUT_W'(w_clamp);
    assign sat_ovf = (w_sum64 > w_clamp);
`else
    assign sat_pix = OUT_W'(w_clamp);
    assign sat_ovf = (w_sum64 != w_clamp);
`endif

endmodule

`default_nettype wire

// File: rtl/conv_mac_unit.sv
//------------------------------------------------------------------------------
// Module   : conv_mac_unit
// Brief    : Streaming KSIZE*KSIZE multiply-accumulate for one convolution
//            output pixel with bias, saturation and optional ReLU (MAC_RELU_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module conv_mac_unit
    import cnn_pkg::*;
#(
    parameter  int DATA_W  = c_data_w_def,
    parameter  int KSIZE   = c_ksize_def,
    parameter  int ACC_W   = 2*DATA_W + $clog2(KSIZE*KSIZE) + 1,
    parameter  int OUT_W   = c_out_w_def,
    localparam int c_taps  = KSIZE*KSIZE,
    localparam int c_tap_w = tap_cnt_w(c_taps)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] kernel_weights,
    input  logic signed [DATA_W-1:0] in_pix,
    input  logic signed [OUT_W-1:0]  bias,
    output logic [c_tap_w-1:0]       tap_idx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_pix,
    output logic                     ovf
);

    mac_state_t                r_state;
    logic signed [ACC_W-1:0]   r_acc;
    logic [c_tap_w-1:0]        r_tap;
    logic signed [OUT_W-1:0]   r_out_pix;
    logic                      r_ovf;

    logic signed [2*DATA_W-1:0] w_prod_raw;
    logic signed [ACC_W-1:0]    w_prod;
    logic                       w_fire;
    logic                       w_last;
    logic signed [OUT_W-1:0]    w_sat_pix;
    logic                       w_sat_ovf;

    assign in_ready   = (r_state == ACCUM) | out_ready;
    assign w_fire     = in_valid & in_ready & ~clear;
    assign w_last     = (r_tap == c_tap_w'(c_taps - 1));
    assign w_prod_raw = kernel_weights * in_pix;
    assign w_prod     = ACC_W'(w_prod_raw);

    mac_sat_stage #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .acc     (r_acc),
        .prod    (w_prod),
        .bias    (bias),
        .sat_pix (w_sat_pix),
        .sat_ovf (w_sat_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ACCUM;
            r_acc     <= '0;
            r_tap     <= '0;
            r_out_pix <= '0;
            r_ovf     <= 1'b0;
        end else begin
            // A clear drops the partial window but leaves any pending result alone.
            if (clear) begin
                r_acc <= '0;
                r_tap <= '0;
            end else if (w_fire) begin
                if (w_last) begin
                    r_acc <= '0;
                    r_tap <= '0;
                end else begin
                    r_acc <= r_acc + w_prod;
                    r_tap <= r_tap + 1'b1;
                end
            end

            if (w_fire && w_last) begin
                r_out_pix <= w_sat_pix;
                r_ovf     <= w_sat_ovf;
                r_state   <= HOLD;
            end else if ((r_state == HOLD) && out_ready) begin
                r_state   <= ACCUM;
            end
        end
    end

    assign tap_idx   = r_tap;
    assign out_valid = (r_state == HOLD);
    assign out_pix   = r_out_pix;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire
